// File: rtl/spi_peripheral_tx.sv
// rtl/spi_peripheral_tx.sv - SPI mode-0 peripheral transmitter driving CIPO from a one-entry holding register
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   SCLK, spi_cs_n    SPI clock and active-low chip select from the controller (asynchronous)
//   CIPO, cipo_oe     serial data to the controller and its pad output enable
//   tx_enable         when low, chip select is ignored while idle
//   tx_data/valid/ready  core-side byte handshake into the holding register
//   byte_sent         pulse when a full frame has been shifted out
//   underrun          pulse when FILL_BYTE is loaded because the holding register was empty
//   tx_abort          pulse when chip select deasserts mid-frame
//   busy              high while not idle
module spi_peripheral_tx #(
    parameter int                   DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] FILL_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCLK,
    input  logic                 spi_cs_n,
    output logic                 CIPO,
    output logic                 cipo_oe,
    input  logic                 tx_enable,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 byte_sent,
    output logic                 underrun,
    output logic                 tx_abort,
    output logic                 busy
);

    localparam int                 CNT_W    = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_q1, sclk_q2;
    logic cs_q1, cs_q2;
    logic sclk_rise, sclk_fall, cs_act;

    logic [DATA_BITS-1:0] hold;
    logic                 hold_valid;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 load_now;
    logic                 capture;

    // Two-flop synchronizers; reset to the idle bus levels so no edge is seen on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q1 <= 1'b0;
            sclk_q2 <= 1'b0;
            cs_q1   <= 1'b1;
            cs_q2   <= 1'b1;
        end else begin
            sclk_q1 <= SCLK;
            sclk_q2 <= sclk_q1;
            cs_q1   <= spi_cs_n;
            cs_q2   <= cs_q1;
        end
    end

    assign sclk_rise = sclk_q1 & ~sclk_q2;
    assign sclk_fall = ~sclk_q1 & sclk_q2;
    assign cs_act    = ~cs_q2;

    assign tx_ready  = ~hold_valid;
    assign capture   = tx_valid & tx_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cipo_oe    = 1'b0;
        CIPO       = 1'b0;
        load_now   = 1'b0;
        byte_sent  = 1'b0;
        tx_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_act && tx_enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // The load always consumes the held byte, even if CS is already gone.
                load_now   = 1'b1;
                state_next = cs_act ? SHIFT : IDLE;
            end
            SHIFT: begin
                cipo_oe = 1'b1;
                CIPO    = shift_reg[DATA_BITS-1];
                if (!cs_act) begin
                    state_next = IDLE;
                    tx_abort   = (bit_cnt != '0) && (bit_cnt < CNT_FULL);
                end else if (sclk_fall && (bit_cnt == CNT_FULL)) begin
                    // Frame complete: reload in place so back-to-back frames need no CS toggle.
                    byte_sent = 1'b1;
                    load_now  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign underrun = load_now & ~hold_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
        end else begin
            // capture only happens while empty, so a same-cycle load has already chosen FILL_BYTE
            // and the new byte survives for the next frame.
            if (capture) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
            end else if (load_now) begin
                hold_valid <= 1'b0;
            end

            if (load_now) begin
                shift_reg <= hold_valid ? hold : FILL_BYTE;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                if (!cs_act) begin
                    bit_cnt <= '0;
                end else if (sclk_rise && (bit_cnt < CNT_FULL)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (sclk_fall && (bit_cnt < CNT_FULL)) begin
                    shift_reg <= {shift_reg[DATA_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral_tx.sv
// tb/tb_spi_peripheral_tx.sv - directed self-checking bench for spi_peripheral_tx
module tb_spi_peripheral_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       CIPO;
    logic       cipo_oe;
    logic       tx_enable = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       byte_sent;
    logic       underrun;
    logic       tx_abort;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_under = 0;
    int n_abort = 0;

    spi_peripheral_tx #(
        .DATA_BITS(8),
        .FILL_BYTE(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SCLK     (SCLK),
        .spi_cs_n (spi_cs_n),
        .CIPO     (CIPO),
        .cipo_oe  (cipo_oe),
        .tx_enable(tx_enable),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .byte_sent(byte_sent),
        .underrun (underrun),
        .tx_abort (tx_abort),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_sent) n_sent++;
        if (underrun)  n_under++;
        if (tx_abort)  n_abort++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!tx_ready) check("push_ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Controller samples CIPO just before each SCLK rise; 6 clk per phase.
    task automatic spi_cycles(input int n, inout logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            bits = {bits[30:0], CIPO};
            SCLK = 1'b1;
            tick(6);
            SCLK = 1'b0;
            tick(6);
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        tick(5);
    endtask

    initial begin
        logic [31:0] bits;
        int s_sent, s_under, s_abort;

        // Reset state
        #1;
        check("rst_cipo", 32'(CIPO), 32'd0);
        check("rst_oe", 32'(cipo_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {29'd0, byte_sent, underrun, tx_abort}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // 1: single byte 0xA5, MSB latency
        s_sent = n_sent; s_under = n_under; s_abort = n_abort;
        push(8'hA5);
        check("t1_ready_after_push", 32'(tx_ready), 32'd0);
        spi_cs_n = 1'b0;
        tick(3);
        check("t1_oe_at_3clk", 32'(cipo_oe), 32'd0);
        tick(1);
        check("t1_oe_at_4clk", 32'(cipo_oe), 32'd1);
        check("t1_msb_at_4clk", 32'(CIPO), 32'd1);
        check("t1_ready_after_load", 32'(tx_ready), 32'd1);
        tick(4);
        bits = 0;
        spi_cycles(8, bits);
        check("t1_bits", bits & 32'hFF, 32'hA5);
        check("t1_byte_sent", 32'(n_sent - s_sent), 32'd1);
        check("t1_underrun_on_reload", 32'(n_under - s_under), 32'd1);
        cs_high();
        check("t1_no_abort", 32'(n_abort - s_abort), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: back-to-back 0x3C, 0xC3 without CS toggle
        s_sent = n_sent; s_under = n_under;
        push(8'h3C);
        cs_low();
        push(8'hC3);
        bits = 0;
        spi_cycles(15, bits);
        check("t2_no_underrun", 32'(n_under - s_under), 32'd0);
        spi_cycles(1, bits);
        check("t2_bits", bits & 32'hFFFF, 32'h3CC3);
        check("t2_byte_sent", 32'(n_sent - s_sent), 32'd2);
        cs_high();

        // 3: empty hold sends fill; byte written mid-frame goes out next
        s_sent = n_sent; s_under = n_under;
        cs_low();
        check("t3_underrun_load", 32'(n_under - s_under), 32'd1);
        bits = 0;
        spi_cycles(4, bits);
        push(8'h96);
        spi_cycles(4, bits);
        check("t3_fill_bits", bits & 32'hFF, 32'h00);
        check("t3_underrun_still", 32'(n_under - s_under), 32'd1);
        bits = 0;
        spi_cycles(8, bits);
        check("t3_next_frame", bits & 32'hFF, 32'h96);
        check("t3_byte_sent", 32'(n_sent - s_sent), 32'd2);
        cs_high();

        // 4: abort after 3 rises of 0xFF, then new frame
        s_abort = n_abort;
        push(8'hFF);
        cs_low();
        bits = 0;
        spi_cycles(3, bits);
        check("t4_partial_bits", bits & 32'h7, 32'h7);
        spi_cs_n = 1'b1;
        tick(3);
        check("t4_oe_off", 32'(cipo_oe), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_abort", 32'(n_abort - s_abort), 32'd1);
        tick(2);
        push(8'h81);
        cs_low();
        bits = 0;
        spi_cycles(8, bits);
        check("t4_new_frame", bits & 32'hFF, 32'h81);
        cs_high();
        check("t4_abort_once", 32'(n_abort - s_abort), 32'd1);

        // 5: tx_enable gating
        tx_enable = 1'b0;
        push(8'h55);
        spi_cs_n = 1'b0;
        tick(10);
        check("t5_oe_gated", 32'(cipo_oe), 32'd0);
        check("t5_busy_gated", 32'(busy), 32'd0);
        check("t5_hold_kept", 32'(tx_ready), 32'd0);
        tx_enable = 1'b1;
        tick(8);
        check("t5_oe_on", 32'(cipo_oe), 32'd1);
        bits = 0;
        spi_cycles(8, bits);
        check("t5_bits", bits & 32'hFF, 32'h55);
        cs_high();

        // 6: reset mid-frame
        push(8'hF0);
        cs_low();
        bits = 0;
        spi_cycles(3, bits);
        s_sent = n_sent; s_under = n_under; s_abort = n_abort;
        rst = 1'b1;
        #1;
        check("t6_cipo", 32'(CIPO), 32'd0);
        check("t6_oe", 32'(cipo_oe), 32'd0);
        check("t6_ready", 32'(tx_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        tick(3);
        spi_cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        check("t6_no_sent", 32'(n_sent - s_sent), 32'd0);
        check("t6_no_abort", 32'(n_abort - s_abort), 32'd0);
        check("t6_no_underrun", 32'(n_under - s_under), 32'd0);
        check("t6_idle_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
